// File: rtl/toy_dmem_responder.sv
// toy_dmem_responder: target end of the RISC_TOY data-memory interface.
// Word-addressed RAM plus an MMIO block (TX FIFO, free-running cycle counter, scratch register).
module toy_dmem_responder #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        TX_VALID,
  output logic [31:0] TX_DATA,
  input  logic        TX_READY,
  output logic        TX_OVF
);

  localparam int               FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT   = FIFO_DEPTH[FIFO_AW:0];

  localparam logic [3:0] OFF_TXDATA  = 4'd0;
  localparam logic [3:0] OFF_STATUS  = 4'd1;
  localparam logic [3:0] OFF_CYCLE   = 4'd2;
  localparam logic [3:0] OFF_SCRATCH = 4'd3;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              is_mmio;
  logic [3:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              ram_re;
  logic              mmio_we;
  logic              mmio_re;
  logic              unused_addr_bits;

  assign is_mmio  = DADDR[29];
  assign mmio_off = DADDR[3:0];
  assign ram_idx  = DADDR[RAM_AW-1:0];

  // Requests are ignored while reset is asserted, including RAM writes.
  assign ram_we  = RSTN & DREQ &  DRW & ~is_mmio;
  assign ram_re  = RSTN & DREQ & ~DRW & ~is_mmio;
  assign mmio_we = DREQ &  DRW &  is_mmio;
  assign mmio_re = DREQ & ~DRW &  is_mmio;

  assign unused_addr_bits = ^DADDR[28:RAM_AW];

  // ---------------------------------------------------------------------------
  // Data RAM: not reset, registered read port
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [2**RAM_AW];
  logic [31:0] ram_rdata_q;

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram_q[ram_idx] <= DWDATA;
    end
    if (ram_re) begin
      ram_rdata_q <= ram_q[ram_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // MMIO state
  // ---------------------------------------------------------------------------
  logic [31:0]      fifo_mem_q [FIFO_DEPTH];
  logic [31:0]      fifo_mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      mmio_rdata_q, mmio_rdata_d;
  logic             rd_sel_ram_q, rd_sel_ram_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        ovf_set;
  logic        ovf_clr;
  logic [31:0] status_word;
  logic [31:0] mmio_rdata;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & TX_READY;
  assign push_req   = mmio_we & (mmio_off == OFF_TXDATA);
  // A push into a full FIFO still lands when a pop frees a slot on the same edge.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign ovf_clr    = mmio_we & (mmio_off == OFF_STATUS) & DWDATA[2];

  assign status_word = {20'b0, 4'(count_q), 5'b0, ovf_q, fifo_empty, fifo_full};

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_STATUS:  mmio_rdata = status_word;
      OFF_CYCLE:   mmio_rdata = cycle_q;
      OFF_SCRATCH: mmio_rdata = scratch_q;
      default:     mmio_rdata = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_mem_d[i] = fifo_mem_q[i];
    end
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    cycle_d      = cycle_q + 32'd1;
    scratch_d    = scratch_q;
    mmio_rdata_d = mmio_rdata_q;
    rd_sel_ram_d = rd_sel_ram_q;

    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = DWDATA;
      wr_ptr_d             = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Overflow set takes priority over a software clear.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (mmio_we && mmio_off == OFF_CYCLE) begin
      cycle_d = DWDATA;
    end
    if (mmio_we && mmio_off == OFF_SCRATCH) begin
      scratch_d = DWDATA;
    end

    // DRDATA is the RAM read register or the MMIO read register, chosen by the last read.
    if (ram_re) begin
      rd_sel_ram_d = 1'b1;
    end else if (mmio_re) begin
      rd_sel_ram_d = 1'b0;
      mmio_rdata_d = mmio_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      cycle_q      <= '0;
      scratch_q    <= '0;
      mmio_rdata_q <= '0;
      rd_sel_ram_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      cycle_q      <= cycle_d;
      scratch_q    <= scratch_d;
      mmio_rdata_q <= mmio_rdata_d;
      rd_sel_ram_q <= rd_sel_ram_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign DRDATA   = rd_sel_ram_q ? ram_rdata_q : mmio_rdata_q;
  assign TX_VALID = ~fifo_empty;
  assign TX_DATA  = fifo_mem_q[rd_ptr_q];
  assign TX_OVF   = ovf_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Scoreboard bench for toy_dmem_responder: stimulus queues expected results,
// a single negedge monitor pops and compares read data, sink transfers and flag checks.
module tb_toy_dmem_responder;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        DREQ = 1'b0;
  logic        DRW = 1'b0;
  logic [29:0] DADDR = '0;
  logic [31:0] DWDATA = '0;
  logic [31:0] DRDATA;
  logic        TX_VALID;
  logic [31:0] TX_DATA;
  logic        TX_READY = 1'b0;
  logic        TX_OVF;

  always #5 clk = ~clk;

  toy_dmem_responder dut (
    .CLK      (clk),
    .RSTN     (RSTN),
    .DREQ     (DREQ),
    .DRW      (DRW),
    .DADDR    (DADDR),
    .DWDATA   (DWDATA),
    .DRDATA   (DRDATA),
    .TX_VALID (TX_VALID),
    .TX_DATA  (TX_DATA),
    .TX_READY (TX_READY),
    .TX_OVF   (TX_OVF)
  );

  localparam logic [29:0] MMIO    = 30'h2000_0000;
  localparam logic [29:0] A_TX    = MMIO | 30'd0;
  localparam logic [29:0] A_STAT  = MMIO | 30'd1;
  localparam logic [29:0] A_CYC   = MMIO | 30'd2;
  localparam logic [29:0] A_SCR   = MMIO | 30'd3;

  typedef enum int {K_OVF, K_VALID, K_TXDATA, K_DRDATA, K_TXQ, K_RDQ} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } flag_t;

  logic [31:0] rd_exp  [$];
  string       rd_name [$];
  logic [31:0] tx_exp  [$];
  flag_t       flag_q  [$];

  int   checks = 0;
  int   errors = 0;
  logic rd_issued = 1'b0;

  always @(posedge clk) rd_issued <= DREQ && !DRW && RSTN;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("%0t FAIL %s got=%h expected=%h", $time, name, act, exp);
    end else begin
      $display("%0t ok   %s got=%h", $time, name, act);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] act;
    string       nm;
    flag_t       f;
    if (rd_issued) begin
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("%0t FAIL rd_unexpected got=%h expected=none", $time, DRDATA);
      end else begin
        e  = rd_exp.pop_front();
        nm = rd_name.pop_front();
        cmp(nm, DRDATA, e);
      end
    end
    if (!RSTN) begin
      tx_exp.delete();
    end else if (TX_VALID && TX_READY) begin
      if (tx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("%0t FAIL tx_unexpected got=%h expected=none", $time, TX_DATA);
      end else begin
        e = tx_exp.pop_front();
        cmp("tx_word", TX_DATA, e);
      end
    end
    while (flag_q.size() != 0) begin
      f = flag_q.pop_front();
      case (f.kind)
        K_OVF:    act = {31'b0, TX_OVF};
        K_VALID:  act = {31'b0, TX_VALID};
        K_TXDATA: act = TX_DATA;
        K_DRDATA: act = DRDATA;
        K_TXQ:    act = tx_exp.size();
        default:  act = rd_exp.size();
      endcase
      cmp(f.name, act, f.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    DREQ = 1'b1; DRW = 1'b1; DADDR = a; DWDATA = d;
    step();
    DREQ = 1'b0; DRW = 1'b0;
  endtask

  task automatic rd(input logic [29:0] a, input logic [31:0] e, input string n);
    DREQ = 1'b1; DRW = 1'b0; DADDR = a;
    rd_exp.push_back(e);
    rd_name.push_back(n);
    step();
    DREQ = 1'b0;
  endtask

  task automatic push_tx(input logic [31:0] d);
    tx_exp.push_back(d);
    wr(A_TX, d);
  endtask

  task automatic flag(input kind_e k, input logic [31:0] e, input string n);
    flag_t f;
    f.kind = k;
    f.exp  = e;
    f.name = n;
    flag_q.push_back(f);
  endtask

  task automatic drain(input string n);
    TX_READY = 1'b1;
    for (int i = 0; i < 20 && TX_VALID; i++) step();
    TX_READY = 1'b0;
    flag(K_VALID, 32'd0, {n, "_valid_low"});
    flag(K_TXQ, 32'd0, {n, "_all_received"});
  endtask

  initial begin
    step();
    step();
    RSTN = 1'b1;
    flag(K_DRDATA, 32'd0, "reset_drdata");
    flag(K_VALID, 32'd0, "reset_tx_valid");
    flag(K_TXDATA, 32'd0, "reset_tx_data");
    flag(K_OVF, 32'd0, "reset_tx_ovf");
    step();

    // RAM write/read and address aliasing
    wr(30'h005, 32'hDEAD_BEEF);
    rd(30'h005, 32'hDEAD_BEEF, "ram_read_005");
    rd(30'h405, 32'hDEAD_BEEF, "ram_alias_405");

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) push_tx(i);
    rd(A_STAT, 32'h0000_0801, "status_full");
    wr(A_TX, 32'd9);
    rd(A_STAT, 32'h0000_0805, "status_full_ovf");
    flag(K_OVF, 32'd1, "tx_ovf_set");
    drain("drain1");
    rd(A_STAT, 32'h0000_0006, "status_empty_ovf");

    // Clear ovf: bit 2 clear is ignored, bit 2 set clears
    wr(A_STAT, 32'hFFFF_FFFB);
    flag(K_OVF, 32'd1, "ovf_no_clear");
    wr(A_STAT, 32'h0000_0004);
    flag(K_OVF, 32'd0, "ovf_cleared");
    rd(A_STAT, 32'h0000_0002, "status_empty");

    // Push into a full FIFO while the sink pops that same edge
    for (int i = 0; i < 8; i++) push_tx(32'h10 + i);
    TX_READY = 1'b1;
    push_tx(32'hAA);
    TX_READY = 1'b0;
    flag(K_OVF, 32'd0, "full_push_pop_no_ovf");
    rd(A_STAT, 32'h0000_0801, "status_full_after_push_pop");
    drain("drain2");

    // Cycle counter load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC, 32'hFFFF_FFFE, "cycle_loaded");
    rd(A_CYC, 32'hFFFF_FFFF, "cycle_plus1");
    rd(A_CYC, 32'h0000_0000, "cycle_wrap");

    // Scratch, alias on upper offset bits, reserved offsets, TXDATA read
    wr(A_SCR, 32'h0000_1234);
    rd(MMIO | 30'h13, 32'h0000_1234, "scratch_alias");
    wr(MMIO | 30'h5, 32'h5555_5555);
    rd(MMIO | 30'h5, 32'h0, "reserved_reads_zero");
    rd(A_TX, 32'h0, "txdata_reads_zero");
    flag(K_VALID, 32'd0, "txdata_read_no_push");

    // Overflow again, then reset in the middle of a drain
    for (int i = 0; i < 8; i++) push_tx(32'h20 + i);
    wr(A_TX, 32'h99);
    flag(K_OVF, 32'd1, "ovf_set_again");
    rd(A_SCR, 32'h0000_1234, "scratch_before_reset");
    TX_READY = 1'b1;
    step();
    step();
    RSTN = 1'b0;
    DREQ = 1'b1; DRW = 1'b0; DADDR = A_SCR;
    step();
    RSTN = 1'b1;
    DREQ = 1'b0;
    TX_READY = 1'b0;
    flag(K_VALID, 32'd0, "midreset_tx_valid");
    flag(K_DRDATA, 32'd0, "midreset_drdata");
    flag(K_TXDATA, 32'd0, "midreset_tx_data");
    flag(K_OVF, 32'd0, "midreset_tx_ovf");
    rd(A_CYC, 32'h0, "midreset_cycle_restart");
    rd(A_SCR, 32'h0, "midreset_scratch");
    rd(30'h005, 32'hDEAD_BEEF, "ram_kept_after_reset");

    step();
    step();
    flag(K_RDQ, 32'd0, "all_reads_checked");
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
